// File: rtl/spram_req_ctrl_if.sv
// Request/response channel bundle between an initiator and spram_req_ctrl.
// Optional macro: SPRAM_REQ_CTRL_WRITE_ACK_EN adds rsp_is_wr to the response channel.
interface spram_req_ctrl_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    // Request channel
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    // Response channel
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
`ifdef SPRAM_REQ_CTRL_WRITE_ACK_EN
    logic          rsp_is_wr;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_is_wr
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_is_wr
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
`endif
endinterface

// File: rtl/spram_req_ctrl.sv
// Initiator-side front end for a single-port RAM with registered read output.
// Requests drive the RAM pins combinationally; read data returning one cycle
// later is captured into a small response FIFO and handed back in order.
// A credit counter (in-flight reads + FIFO occupancy) throttles reads so the
// FIFO can never overflow, regardless of response backpressure.
// Optional macro: SPRAM_REQ_CTRL_WRITE_ACK_EN -- writes also take a credit and
// return an in-order acknowledge carrying the written data (rsp_is_wr = 1).
module spram_req_ctrl #(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int RSP_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    spram_req_ctrl_if.slave            bus,
    output logic [AW-1:0]              ram_address,
    output logic                       ram_wren,
    output logic [DW-1:0]              ram_data,
    input  logic [DW-1:0]              ram_out,
    output logic [$clog2(RSP_DEPTH):0] outstanding
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    logic          req_ready_int;
    logic          credit_ok;
    logic          acc;
    logic          issue;
    logic          pop;
    logic          push;
    logic          full;
    logic          rsp_valid_int;

    // One-cycle stage that lines up with the RAM's registered output.
    logic          stg_valid;
`ifdef SPRAM_REQ_CTRL_WRITE_ACK_EN
    logic          stg_is_wr;
    logic [DW-1:0] stg_wdata;
    logic          fifo_is_wr [RSP_DEPTH];
`endif

    logic [DW-1:0] push_data;
    logic [DW-1:0] fifo_data [RSP_DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [PW:0]   fifo_count;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;

    // Credit check, accept decision and RAM pin drive, all from the current request.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        credit_ok     = (outstanding < DEPTH_C);
        req_ready_int = credit_ok;
        issue         = 1'b0;
`ifdef SPRAM_REQ_CTRL_WRITE_ACK_EN
        // Writes and reads share the credit pool; both produce a response.
        acc           = bus.req_valid & req_ready_int;
        issue         = acc;
`else
        // Writes never produce a response, so they bypass the credit check.
        req_ready_int = credit_ok | bus.req_we;
        acc           = bus.req_valid & req_ready_int;
        issue         = acc & ~bus.req_we;
`endif
        ram_address   = bus.req_addr;
        ram_data      = bus.req_wdata;
        // Writes are suppressed while reset is held so a stray request cannot corrupt the RAM.
        ram_wren      = resetn & acc & bus.req_we;
    end

    assign bus.req_ready = req_ready_int;

    // Stage register: marks the cycle in which ram_out (or a write ack) is pushed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            stg_valid <= 1'b0;
`ifdef SPRAM_REQ_CTRL_WRITE_ACK_EN
            stg_is_wr <= 1'b0;
            stg_wdata <= '0;
`endif
        end else begin
            stg_valid <= issue;
`ifdef SPRAM_REQ_CTRL_WRITE_ACK_EN
            stg_is_wr <= bus.req_we;
            stg_wdata <= bus.req_wdata;
`endif
        end
    end

    // FIFO push source: captured RAM data for reads, the staged write data for write acks.
    always_comb begin
        push      = stg_valid;
        push_data = ram_out;
`ifdef SPRAM_REQ_CTRL_WRITE_ACK_EN
        if (stg_is_wr) begin
            push_data = stg_wdata;
        end
`endif
    end

    assign wr_idx        = wr_ptr[PW-1:0];
    assign rd_idx        = rd_ptr[PW-1:0];
    assign fifo_count    = wr_ptr - rd_ptr;
    assign full          = (fifo_count == DEPTH_C);
    assign rsp_valid_int = (fifo_count != '0);
    assign pop           = rsp_valid_int & bus.rsp_ready;

    // FIFO pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are left unreset; the pointers alone define which entries are live.
        if (push) begin
            fifo_data[wr_idx] <= push_data;
`ifdef SPRAM_REQ_CTRL_WRITE_ACK_EN
            fifo_is_wr[wr_idx] <= stg_is_wr;
`endif
        end
    end

    // Credit counter: in-flight plus buffered responses; issue and pop together cancel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outstanding <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Response outputs read straight from the head entry; zero while empty.
    assign bus.rsp_valid = rsp_valid_int;
    assign bus.rsp_rdata = rsp_valid_int ? fifo_data[rd_idx] : '0;
`ifdef SPRAM_REQ_CTRL_WRITE_ACK_EN
    assign bus.rsp_is_wr = rsp_valid_int & fifo_is_wr[rd_idx];
`endif

    // The credit rule alone must keep the FIFO from overflowing.
    a_no_overflow : assert property (@(posedge clk) disable iff (!resetn) !(push && full));

    // The credit counter must always equal the staged entry plus the FIFO occupancy.
    a_credit_match : assert property (@(posedge clk) disable iff (!resetn)
        outstanding == (fifo_count + CW'(stg_valid)));

endmodule

// File: doc/spram_req_ctrl.md
Name: spram_req_ctrl

Overview:
- Initiator-side front end for the 1024x32 single-port RAM.
- Accepts read/write requests over a valid/ready channel and drives the RAM's address/wren/data pins.
- Captures the RAM's registered read output and returns it in order over a valid/ready response channel with backpressure.
- Uses credit-based flow control so no read data is ever lost.

Parameters:
- AW, 10, address width; RAM depth is 2**AW.
- DW, 32, data width.
- RSP_DEPTH, 4, response FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AW  request address.
- req_wdata  in  DW  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DW  read data, in request order.
- ram_address  out  AW  to RAM address.
- ram_wren  out  1  to RAM wren.
- ram_data  out  DW  to RAM data.
- ram_out  in  DW  from RAM out; valid the cycle after a read is issued.
- outstanding  out  $clog2(RSP_DEPTH)+1  in-flight reads plus FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert handled upstream) values:
  - rsp_valid=0, outstanding=0, inflight flag=0.
  - FIFO pointers=0, rsp_rdata=0.
  - ram_wren=0 while resetn=0.
- Accept condition: acc = req_valid & req_ready.
- RAM drive is combinational from the request:
  - ram_address = req_addr.
  - ram_data = req_wdata.
  - ram_wren = acc & req_we.
- Read issue: acc & !req_we sets the registered inflight flag for exactly one cycle.
- Read capture: when inflight=1, ram_out is pushed into the FIFO at the end of that cycle.
- Read latency: read accepted in cycle T → rsp_valid=1 in cycle T+2 at the earliest, with rsp_rdata = mem[addr].
- Writes:
  - Take effect at the edge ending cycle T.
  - Produce no response.
  - Are always accepted: req_ready=1 for writes regardless of credits.
- Read credits:
  - req_ready for a read = (outstanding < RSP_DEPTH).
  - outstanding is computed from registered state only; no same-cycle pop credit.
  - req_ready must not depend on req_valid.
  - req_ready for a read may depend on req_we.
- outstanding update, each edge:
  - +1 on a read issue.
  - −1 on a pop (rsp_valid & rsp_ready).
  - Unchanged when both happen in the same cycle.
- FIFO behaviour:
  - Push and pop in the same cycle are both honoured.
  - Pointers wrap modulo RSP_DEPTH.
  - Overflow is impossible by the credit rule; the design must assert this in simulation.
- Ordering: responses come out strictly in read-issue order. A write between two reads does not disturb ram_out capture, because the RAM holds out on write cycles.
- Read-after-write to the same address in consecutive cycles returns the new data.
- rsp_valid/rsp_rdata hold stable while rsp_valid=1 & rsp_ready=0.
- Throughput: with rsp_ready held at 1 and RSP_DEPTH≥4, back-to-back reads sustain 1 per cycle.
- Mid-operation reset: the inflight read and all FIFO contents are discarded. RAM contents are not cleared.

Optional Feature:
- Macro: SPRAM_REQ_CTRL_WRITE_ACK_EN.
- When defined:
  - Every accepted write also consumes a credit.
  - Each write pushes a response entry in order, with rsp_rdata = written data.
  - Adds output rsp_is_wr (1 bit): 1 for write acks, 0 for reads.
  - Writes obey the same req_ready credit rule as reads.
- When undefined: writes are fire-and-forget, and the rsp_is_wr port is absent.

Test Plan:
- Write addr 0x005 data 0xDEADBEEF, then read 0x005 → rsp_valid exactly 2 cycles after the read accept, rsp_rdata=0xDEADBEEF, outstanding returns to 0.
- 16 back-to-back reads of addrs 0..15 (preloaded with addr*3) with rsp_ready=1 → req_ready stays 1; 16 responses 0,3,…,45 in order on consecutive cycles.
- rsp_ready=0, issue reads continuously → exactly 4 accepted, then req_ready=0 for reads; a write is still accepted. Raise rsp_ready → 4 responses drain in order and reads resume.
- Alternating write 0x3FF/0x12345678 and read 0x3FF on every cycle → each read returns the latest write; no response is generated for writes (macro off).
- Assert resetn low with 2 reads buffered and 1 in flight → rsp_valid=0 and outstanding=0 immediately; after release, a read of a previously written addr returns the correct data.
- With SPRAM_REQ_CTRL_WRITE_ACK_EN: write 0x010/0xA5A5A5A5 then read 0x010 → two responses: {rsp_is_wr=1, 0xA5A5A5A5} then {rsp_is_wr=0, 0xA5A5A5A5}.
